// File: rtl/muldiv_hilo_unit.sv
// HI/LO multiply-divide unit for the execute stage.
// Single-cycle MULT/MULTU, 33-cycle radix-2 restoring DIV/DIVU, MTHI/MTLO,
// and the MFHI/MFLO read mux feeding the E-stage result selection.
module muldiv_hilo_unit #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] hilo_result_o
);

    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    localparam int CW = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [64:0] r_rq, w_rq_nxt;        // {remainder[32:0], quotient[31:0]}
    logic [31:0] r_dvs, w_dvs_nxt;      // divisor magnitude
    logic        r_neg_q, w_neg_q_nxt;
    logic        r_neg_r, w_neg_r_nxt;
    logic        w_stall;

    logic        w_signed_div;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_abs, w_b_abs;
    logic [63:0] w_prod_s, w_prod_u;
    logic [64:0] w_shift, w_step;
    logic [33:0] w_diff;
    logic        w_last;

    assign w_signed_div = (alucontrolE == OP_DIV);
    assign w_a_neg      = w_signed_div & srcaE[31];
    assign w_b_neg      = w_signed_div & srcbE[31];
    assign w_a_abs      = w_a_neg ? (32'd0 - srcaE) : srcaE;
    assign w_b_abs      = w_b_neg ? (32'd0 - srcbE) : srcbE;

    // Operands are extended to 64 bits so the low 64 product bits are exact.
    assign w_prod_s = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
    assign w_prod_u = {32'd0, srcaE} * {32'd0, srcbE};

    assign w_shift = {r_rq[63:0], 1'b0};
    assign w_diff  = {1'b0, w_shift[64:32]} - {2'b00, r_dvs};
    assign w_last  = (r_cnt == CW'(DIV_ITER - 1));

    // One restoring step: subtract when the trial remainder stays non-negative.
    always_comb begin
        w_step = w_shift;
        if (!w_diff[33]) begin
            w_step = {w_diff[32:0], w_shift[31:1], 1'b1};
        end else begin
            w_step = w_shift;
        end
    end

    // Next-state, HI/LO update and stall generation (stall never looks at stall_i).
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_cnt_nxt   = r_cnt;
        w_rq_nxt    = r_rq;
        w_dvs_nxt   = r_dvs;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    case (alucontrolE)
                        OP_MULT: begin
                            w_hi_nxt = w_prod_s[63:32];
                            w_lo_nxt = w_prod_s[31:0];
                        end
                        OP_MULTU: begin
                            w_hi_nxt = w_prod_u[63:32];
                            w_lo_nxt = w_prod_u[31:0];
                        end
                        OP_MTHI: w_hi_nxt = srcaE;
                        OP_MTLO: w_lo_nxt = srcaE;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched and never stalls.
                            if (srcbE != 32'd0) begin
                                w_rq_nxt    = {33'd0, w_a_abs};
                                w_dvs_nxt   = w_b_abs;
                                w_neg_q_nxt = w_a_neg ^ w_b_neg;
                                w_neg_r_nxt = w_a_neg;
                                w_cnt_nxt   = '0;
                                w_state_nxt = S_DIV;
                                w_stall     = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                w_stall   = 1'b1;
                w_rq_nxt  = w_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_lo_nxt    = r_neg_q ? (32'd0 - w_step[31:0])  : w_step[31:0];
                    w_hi_nxt    = r_neg_r ? (32'd0 - w_step[63:32]) : w_step[63:32];
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            S_DONE: begin
                // The divide is still in E until the other stall source releases it.
                if (stall_i) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush cancels everything in flight and suppresses any HI/LO write.
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_cnt   <= '0;
            r_rq    <= 65'd0;
            r_dvs   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rq    <= w_rq_nxt;
            r_dvs   <= w_dvs_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
        end
    end

    // MFHI/MFLO read mux; zero for every other operation.
    always_comb begin
        case (alucontrolE)
            OP_MFHI: hilo_result_o = r_hi;
            OP_MFLO: hilo_result_o = r_lo;
            default: hilo_result_o = 32'd0;
        endcase
    end

    assign stall_o = w_stall;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit.
module tb_muldiv_hilo_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hilo_result_o;

    int n_pass  = 0;
    int n_total = 0;
    int cnt;
    logic seen;

    muldiv_hilo_unit #(.DIV_ITER(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alucontrolE   (alucontrolE),
        .srcaE         (srcaE),
        .srcbE         (srcbE),
        .valid_i       (valid_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .hilo_result_o (hilo_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        alucontrolE = op;
        srcaE       = a;
        srcbE       = b;
        valid_i     = 1'b1;
    endtask

    // Counts stall cycles starting at the current sample point, bounded.
    task automatic run_div(output int n);
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; alucontrolE = 8'h00; srcaE = 32'd0; srcbE = 32'd0;
        valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        alucontrolE = 8'h12;
        #1;
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_mflo", hilo_result_o, 32'h0);

        // MULT signed
        issue(8'h18, 32'hFFFFFFFE, 32'd3);
        #1;
        chk("mult_stall", {31'd0, stall_o}, 32'd0);
        chk("mult_result_zero", hilo_result_o, 32'h0);
        tick();
        chk("mult_hi", hi_o, 32'hFFFFFFFF);
        chk("mult_lo", lo_o, 32'hFFFFFFFA);
        alucontrolE = 8'h10;
        #1;
        chk("mfhi", hilo_result_o, 32'hFFFFFFFF);

        // MULTU
        issue(8'h19, 32'hFFFFFFFE, 32'd3);
        tick();
        chk("multu_hi", hi_o, 32'h00000002);
        chk("multu_lo", lo_o, 32'hFFFFFFFA);
        chk("multu_stall", {31'd0, stall_o}, 32'd0);

        // DIV -7 / 2
        issue(8'h1A, 32'hFFFFFFF9, 32'd2);
        #1;
        run_div(cnt);
        valid_i = 1'b0;
        chk("div_stall_cycles", 32'(cnt), 32'd33);
        chk("div_lo", lo_o, 32'hFFFFFFFD);
        chk("div_hi", hi_o, 32'hFFFFFFFF);
        tick();

        // DIVU 100 / 7
        issue(8'h1B, 32'd100, 32'd7);
        #1;
        run_div(cnt);
        valid_i = 1'b0;
        chk("divu_stall_cycles", 32'(cnt), 32'd33);
        chk("divu_lo", lo_o, 32'h0000000E);
        chk("divu_hi", hi_o, 32'h00000002);
        tick();

        // Flush in the 10th DIV cycle
        issue(8'h11, 32'h1234, 32'd0); tick();
        issue(8'h13, 32'h5678, 32'd0); tick();
        issue(8'h1A, 32'd100, 32'd7);
        tick();                               // start edge: now in DIV cycle 1
        for (int i = 0; i < 9; i++) tick();   // DIV cycle 10
        chk("flush_pre_stall", {31'd0, stall_o}, 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        chk("flush_hi", hi_o, 32'h1234);
        chk("flush_lo", lo_o, 32'h5678);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | stall_o;
            tick();
        end
        chk("flush_idle", {31'd0, seen}, 32'd0);
        chk("flush_hi_late", hi_o, 32'h1234);
        chk("flush_lo_late", lo_o, 32'h5678);

        // Divide by zero
        issue(8'h11, 32'hAAAA, 32'd0); tick();
        issue(8'h13, 32'hBBBB, 32'd0); tick();
        issue(8'h1A, 32'd5, 32'd0);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | stall_o;
            tick();
        end
        valid_i = 1'b0;
        chk("dbz_stall", {31'd0, seen}, 32'd0);
        chk("dbz_hi", hi_o, 32'hAAAA);
        chk("dbz_lo", lo_o, 32'hBBBB);

        // DIVU held in DONE by stall_i
        issue(8'h1B, 32'd100, 32'd7);
        #1;
        run_div(cnt);
        chk("hold_stall_cycles", 32'(cnt), 32'd33);
        stall_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | stall_o;
            tick();
        end
        seen = seen | stall_o;
        chk("hold_no_restart", {31'd0, seen}, 32'd0);
        chk("hold_lo", lo_o, 32'h0000000E);
        chk("hold_hi", hi_o, 32'h00000002);
        stall_i = 1'b0;
        tick();                               // DONE -> IDLE
        issue(8'h13, 32'h42, 32'd0);
        #1;
        chk("post_hold_stall", {31'd0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("mtlo_lo", lo_o, 32'h42);
        chk("mtlo_hi", hi_o, 32'h00000002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
